// File: rtl/instruction_memory_if.sv
// ----------------------------------------------------------------------------
// instruction_memory_if
//   Fetch/programming bus between the datapath and the instruction store.
//
//   Signals:
//     PC          word index of the instruction to fetch (not a byte address)
//     instruction instruction word at PC (driven by the memory)
//     addr_err    high when PC is beyond the last stored word
//     prog_we     programming write enable   (INSTR_MEM_PROG_EN only)
//     prog_addr   programming word index     (INSTR_MEM_PROG_EN only)
//     prog_data   programming data word      (INSTR_MEM_PROG_EN only)
//
//   Modports:
//     master  fetch stage / programmer side
//     slave   instruction memory side
//
//   Build option: define INSTR_MEM_PROG_EN to add the programming signals.
// ----------------------------------------------------------------------------
interface instruction_memory_if
`ifdef INSTR_MEM_PROG_EN
    #(parameter int unsigned ADDR_W = 8)
`endif
    ;

    logic [31:0]       PC;
    logic [31:0]       instruction;
    logic              addr_err;
`ifdef INSTR_MEM_PROG_EN
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_data;
`endif

    modport master (
        output PC,
`ifdef INSTR_MEM_PROG_EN
        output prog_we,
        output prog_addr,
        output prog_data,
`endif
        input  instruction,
        input  addr_err
    );

    modport slave (
        input  PC,
`ifdef INSTR_MEM_PROG_EN
        input  prog_we,
        input  prog_addr,
        input  prog_data,
`endif
        output instruction,
        output addr_err
    );

endinterface : instruction_memory_if

// File: rtl/instruction_memory.sv
// ----------------------------------------------------------------------------
// instruction_memory
//   Word-addressed instruction store for the single-cycle RISC-V datapath.
//   The fetch path is purely combinational: PC in, 32-bit instruction out.
//   A fixed boot image is (re)loaded asynchronously whenever rst is high.
//
//   Ports:
//     clk   system clock (only clocks the programming port)
//     rst   asynchronous, active-high reset; restores the boot image
//     bus   instruction_memory_if.slave
//             PC (in), instruction (out), addr_err (out)
//             prog_we/prog_addr/prog_data (in, INSTR_MEM_PROG_EN only)
//
//   Parameters:
//     DEPTH   number of 32-bit words (valid indices 0..DEPTH-1)
//     ADDR_W  index bits taken from PC, must equal clog2(DEPTH)
//
//   Build option: INSTR_MEM_PROG_EN enables the synchronous programming port.
//   Without it the array only ever holds the boot image (constant ROM).
// ----------------------------------------------------------------------------
module instruction_memory #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_memory_if.slave  bus
);

    // Boot image contents for a given word index.
    function automatic logic [31:0] boot_word(input int unsigned idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h4000_0033;  // R-type, funct7=0100000
            1:       w = 32'h0000_2083;  // lw  x1, 0(x0)
            2:       w = 32'h0000_0063;  // beq x0, x0, 0
            default: w = '0;
        endcase
        return w;
    endfunction

    logic [31:0] mem_q [DEPTH];
    logic        addr_err_w;

    // Reset has priority over any pending programming write, so an image
    // reload always wins. With the programming port absent the array is only
    // ever written by reset and therefore holds the boot image as a ROM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= boot_word(i);
            end
        end
`ifdef INSTR_MEM_PROG_EN
        else if (bus.prog_we) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
`endif
    end

    // Full 32-bit compare so out-of-range PCs never alias onto low words.
    always_comb begin
        addr_err_w      = (bus.PC >= 32'(DEPTH));
        bus.addr_err    = addr_err_w;
        bus.instruction = '0;
        if (!addr_err_w) begin
            bus.instruction = mem_q[bus.PC[ADDR_W-1:0]];
        end
    end

endmodule : instruction_memory

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

    localparam int unsigned DEPTH = 256;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    instruction_memory_if bus ();

    instruction_memory #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: a plain array plus the range rule.
    logic [31:0] model_mem [DEPTH];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_mem[0] = 32'h4000_0033;
        model_mem[1] = 32'h0000_2083;
        model_mem[2] = 32'h0000_0063;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] pc);
        if (pc >= 32'd256) return 32'h0;
        return model_mem[pc[7:0]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [31:0] pc;
        n_cmp  = 0;
        n_fail = 0;
        bus.PC = 32'h0;
`ifdef INSTR_MEM_PROG_EN
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
`endif
        model_reset();

        // Reset state: boot image visible while rst is high.
        rst = 1'b1;
        #3;
        bus.PC = 32'd0; #1;
        check("rst_word0", bus.instruction, 32'h4000_0033);
        check("rst_err0", {31'b0, bus.addr_err}, 32'd0);
        bus.PC = 32'd300; #1;
        check("rst_err_oob", {31'b0, bus.addr_err}, 32'd1);
        #10;
        rst = 1'b0;
        #7;

        // Directed table.
        vecs.push_back('{32'd0,          32'b01000000000000000000000000110011, 1'b0});
        vecs.push_back('{32'd1,          32'b00000000000000000010000010000011, 1'b0});
        vecs.push_back('{32'd2,          32'b00000000000000000000000001100011, 1'b0});
        vecs.push_back('{32'd3,          32'h0, 1'b0});
        vecs.push_back('{32'd128,        32'h0, 1'b0});
        vecs.push_back('{32'd254,        32'h0, 1'b0});
        vecs.push_back('{32'd255,        32'h0, 1'b0});
        vecs.push_back('{32'd256,        32'h0, 1'b1});
        vecs.push_back('{32'd257,        32'h0, 1'b1});
        vecs.push_back('{32'd258,        32'h0, 1'b1});
        vecs.push_back('{32'h8000_0000,  32'h0, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF,  32'h0, 1'b1});
        vecs.push_back('{32'd0,          32'h4000_0033, 1'b0});
        foreach (vecs[i]) begin
            bus.PC = vecs[i].pc;
            #10;
            check($sformatf("vec%0d_instr", i), bus.instruction, vecs[i].exp_instr);
            check($sformatf("vec%0d_err", i), {31'b0, bus.addr_err}, {31'b0, vecs[i].exp_err});
        end

        // Sweep the zero-filled region.
        for (int i = 3; i <= 254; i++) begin
            bus.PC = i;
            #10;
            check($sformatf("sweep%0d_instr", i), bus.instruction, 32'h0);
            check($sformatf("sweep%0d_err", i), {31'b0, bus.addr_err}, 32'd0);
        end

        // Asynchronous reset pulse between clock edges.
        @(negedge clk);
        #1 rst = 1'b1;
        bus.PC = 32'd1;
        #1 check("pulse_rst_word1", bus.instruction, 32'h0000_2083);
        rst = 1'b0;
        #1 check("pulse_post_word1", bus.instruction, 32'h0000_2083);

`ifdef INSTR_MEM_PROG_EN
        // Write DEAD_BEEF to index 0 with read-during-write observation.
        @(negedge clk);
        bus.PC        = 32'd0;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'd0;
        bus.prog_data = 32'hDEAD_BEEF;
        #1 check("rdw_old", bus.instruction, 32'h4000_0033);
        @(posedge clk);
        #1 check("rdw_new", bus.instruction, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.prog_we = 1'b0;
        model_mem[0] = 32'hDEAD_BEEF;

        // Reset pulse with no clock edge restores the image.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1 check("prog_rst_word0", bus.instruction, 32'h4000_0033);
        model_reset();

        // Writes blocked while rst is high.
        @(negedge clk);
        rst           = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'd5;
        bus.prog_data = 32'hCAFE_F00D;
        bus.PC        = 32'd5;
        @(posedge clk);
        #1 check("rst_block_during", bus.instruction, 32'h0);
        @(negedge clk);
        bus.prog_we = 1'b0;
        rst         = 1'b0;
        #1 check("rst_block_after", bus.instruction, 32'h0);

        // Randomized writes and reads against the model.
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            bus.prog_we   = ($urandom_range(0, 2) == 0);
            bus.prog_addr = 8'($urandom_range(0, 255));
            bus.prog_data = $urandom;
            @(posedge clk);
            #1;
            if (bus.prog_we) model_mem[bus.prog_addr] = bus.prog_data;
            @(negedge clk);
            bus.prog_we = 1'b0;
            case ($urandom_range(0, 3))
                0:       pc = 32'($urandom_range(0, 255));
                1:       pc = 32'(bus.prog_addr);
                2:       pc = 32'($urandom_range(250, 262));
                default: pc = $urandom;
            endcase
            bus.PC = pc;
            #1;
            check($sformatf("rnd%0d_instr pc=%h", it, pc), bus.instruction, model_read(pc));
            check($sformatf("rnd%0d_err pc=%h", it, pc), {31'b0, bus.addr_err},
                  {31'b0, (pc >= 32'd256)});
        end
`else
        // Randomized reads against the boot-image model.
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0:       pc = 32'($urandom_range(0, 7));
                1:       pc = 32'($urandom_range(0, 255));
                2:       pc = 32'($urandom_range(250, 262));
                default: pc = $urandom;
            endcase
            bus.PC = pc;
            #3;
            check($sformatf("rnd%0d_instr pc=%h", it, pc), bus.instruction, model_read(pc));
            check($sformatf("rnd%0d_err pc=%h", it, pc), {31'b0, bus.addr_err},
                  {31'b0, (pc >= 32'd256)});
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_instruction_memory

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- Word-addressed instruction store for the single-cycle RISC-V datapath; the fetch stage presents PC and receives a 32-bit instruction combinationally.
- Holds a fixed boot image that is restored by reset.
- An optional synchronous programming port allows the image to be overwritten at run time.

Parameters:
- DEPTH, 256, number of 32-bit words; valid word indices 0..DEPTH-1.
- ADDR_W, 8, index bits used from PC; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock; used only by the programming port.
- rst  input  1  asynchronous, active-high reset; restores the boot image.
- PC  input  32  word index of the instruction to fetch (not a byte address).
- instruction  output  32  instruction word at PC.
- addr_err  output  1  high when PC >= DEPTH.
- prog_we  input  1  programming write enable (only with INSTR_MEM_PROG_EN).
- prog_addr  input  ADDR_W  programming word index (only with INSTR_MEM_PROG_EN).
- prog_data  input  32  programming data word (only with INSTR_MEM_PROG_EN).

Behaviour:
- Storage: DEPTH x 32-bit array.
- Boot image, loaded while rst is high and held after release:
  - word 0 = 32'h4000_0033 (R-type, funct7=0100000, opcode 0110011)
  - word 1 = 32'h0000_2083 (lw x1, 0(x0))
  - word 2 = 32'h0000_0063 (beq x0, x0, 0)
  - words 3..DEPTH-1 = 32'h0000_0000
- Read path is purely combinational, with no clock involved:
  - instruction = mem[PC[ADDR_W-1:0]] when PC < DEPTH.
  - instruction = 32'h0 when PC >= DEPTH; upper PC bits are compared, so the address never wraps.
  - Output settles within the same delta/propagation after any PC change.
- addr_err = (PC >= DEPTH), combinational.
- Reset:
  - Asserting rst immediately, asynchronously reloads the full boot image into every word.
  - The read path reflects the boot image while rst is high.
  - Reset mid-programming discards any pending write; the image wins.
- Reset values of outputs:
  - During reset, instruction shows the boot-image word at PC.
  - addr_err is purely a function of PC.
- No latency, handshake or state machine on the fetch path.
- X on PC yields X on instruction; no masking is required.

Optional Feature:
- Macro: INSTR_MEM_PROG_EN.
- Defined:
  - prog_we/prog_addr/prog_data ports exist.
  - On rising clk with rst low and prog_we high, mem[prog_addr] <= prog_data.
  - prog_addr is always in range.
  - Read-during-write to the same index:
    - instruction shows the old word until the clock edge.
    - instruction shows the new word combinationally after the edge.
  - rst high blocks writes.
- Undefined:
  - Ports are absent; the array is a constant ROM holding the boot image.
  - clk and rst remain in the port list but have no functional effect beyond rst forcing the boot image.

Test Plan:
- PC=0, wait 10 ns -> instruction = 32'b01000000000000000000000000110011; addr_err=0.
- PC=1 then PC=2, 10 ns each -> 32'b00000000000000000010000010000011, then 32'b00000000000000000000000001100011.
- Sweep PC=3..254 in 10 ns steps -> instruction = 32'h0 every step; addr_err=0; the bench must report 0 errors.
- PC=255 -> 32'h0, addr_err=0; PC=256 and PC=32'hFFFF_FFFF -> instruction=32'h0, addr_err=1; PC=256 must not alias word 0.
- With INSTR_MEM_PROG_EN:
  - Write 32'hDEAD_BEEF to index 0 on a clk edge, then PC=0 -> DEAD_BEEF.
  - Pulse rst asynchronously with no clock -> PC=0 reads 32'h4000_0033 again.
- With INSTR_MEM_PROG_EN, prog_we high while rst high across a clk edge, writing index 5 -> PC=5 still reads 32'h0.
